// File: rtl/seg7_scan_4digit.sv
// Four-digit multiplexed 7-segment driver for a common-anode display.
// One digit is shown per scan slot. Every slot starts with a dead-time window
// that suppresses ghosting. Digit data is snapshotted once per frame so the
// display never tears. Leading-zero blanking, per-digit decimal points and a
// live global enable are supported.
module seg7_scan_4digit #(
    parameter int unsigned CNT_MAX  = 49999,
    parameter int unsigned DEAD_CYC = 50
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] point,
    input  logic       blank_zero,
    input  logic       seg_en,
    output logic [3:0] sel,
    output logic [7:0] seg
);

    localparam logic [19:0] CNT_MAX_V  = 20'(CNT_MAX);
    localparam logic [19:0] DEAD_CYC_V = 20'(DEAD_CYC);

    // 7-segment pattern {g,f,e,d,c,b,a}, active low; non-BCD codes show "-"
    function automatic logic [6:0] seg7_decode(input logic [3:0] dig);
        logic [6:0] pat;
        case (dig)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h3F;
        endcase
        return pat;
    endfunction

    logic [19:0] cnt_r;
    logic [1:0]  idx_r;
    logic        init_r;
    logic [3:0]  snap_unit_r;
    logic [3:0]  snap_ten_r;
    logic [3:0]  snap_hun_r;
    logic [3:0]  snap_tho_r;
    logic [3:0]  snap_point_r;
    logic [3:0]  sel_r;
    logic [7:0]  seg_r;

    logic        wrap_s;
    logic        frame_end_s;
    logic [3:0]  cur_dig_s;
    logic        cur_pt_s;
    logic        blank_s;
    logic [3:0]  sel_nxt_s;
    logic [7:0]  seg_nxt_s;

    // Slot-end and frame-end strobes derived from the scan position
    always_comb begin
        wrap_s      = (cnt_r == CNT_MAX_V);
        frame_end_s = wrap_s && (idx_r == 2'd3);
    end

    // Slot counter and digit index; both keep running while the display is disabled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= 20'd0;
            idx_r <= 2'd0;
        end else if (wrap_s) begin
            cnt_r <= 20'd0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + 20'd1;
            idx_r <= idx_r;
        end
    end

    // First-cycle-after-reset flag that forces an immediate snapshot
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            init_r <= 1'b1;
        end else begin
            init_r <= 1'b0;
        end
    end

    // Frame snapshot of digits and points, taken after reset and at each idx 3->0 wrap
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_unit_r  <= 4'd0;
            snap_ten_r   <= 4'd0;
            snap_hun_r   <= 4'd0;
            snap_tho_r   <= 4'd0;
            snap_point_r <= 4'd0;
        end else if (init_r || frame_end_s) begin
            snap_unit_r  <= unit;
            snap_ten_r   <= ten;
            snap_hun_r   <= hun;
            snap_tho_r   <= tho;
            snap_point_r <= point;
        end else begin
            snap_unit_r  <= snap_unit_r;
            snap_ten_r   <= snap_ten_r;
            snap_hun_r   <= snap_hun_r;
            snap_tho_r   <= snap_tho_r;
            snap_point_r <= snap_point_r;
        end
    end

    // Select the active digit, apply leading-zero blanking and build the next outputs
    always_comb begin
        cur_dig_s = 4'd0;
        cur_pt_s  = 1'b0;
        blank_s   = 1'b0;
        sel_nxt_s = 4'hF;
        case (idx_r)
            2'd0: begin
                cur_dig_s = snap_unit_r;
                cur_pt_s  = snap_point_r[0];
                blank_s   = 1'b0;
                sel_nxt_s = 4'b1110;
            end
            2'd1: begin
                cur_dig_s = snap_ten_r;
                cur_pt_s  = snap_point_r[1];
                blank_s   = (snap_tho_r == 4'd0) && (snap_hun_r == 4'd0) && (snap_ten_r == 4'd0);
                sel_nxt_s = 4'b1101;
            end
            2'd2: begin
                cur_dig_s = snap_hun_r;
                cur_pt_s  = snap_point_r[2];
                blank_s   = (snap_tho_r == 4'd0) && (snap_hun_r == 4'd0);
                sel_nxt_s = 4'b1011;
            end
            2'd3: begin
                cur_dig_s = snap_tho_r;
                cur_pt_s  = snap_point_r[3];
                blank_s   = (snap_tho_r == 4'd0);
                sel_nxt_s = 4'b0111;
            end
            default: begin
                cur_dig_s = 4'd0;
                cur_pt_s  = 1'b0;
                blank_s   = 1'b0;
                sel_nxt_s = 4'hF;
            end
        endcase
        if (blank_zero && blank_s) begin
            seg_nxt_s = {~cur_pt_s, 7'h7F};
        end else begin
            seg_nxt_s = {~cur_pt_s, seg7_decode(cur_dig_s)};
        end
    end

    // Registered drive: everything off when disabled or inside the dead-time window
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_r <= 4'hF;
            seg_r <= 8'hFF;
        end else if (!seg_en) begin
            sel_r <= 4'hF;
            seg_r <= 8'hFF;
        end else if (cnt_r < DEAD_CYC_V) begin
            sel_r <= 4'hF;
            seg_r <= 8'hFF;
        end else begin
            sel_r <= sel_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign sel = sel_r;
    assign seg = seg_r;

endmodule

// File: tb/tb_seg7_scan_4digit.sv
// Self-checking bench for seg7_scan_4digit. The reference model derives the
// expected display from elapsed cycles since reset (slot = cycles / slot length)
// and from a frame-level copy of the inputs.
module tb_seg7_scan_4digit;

    localparam int CM    = 9;
    localparam int DC    = 2;
    localparam int SLOT  = CM + 1;
    localparam int FRAME = 4 * SLOT;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] unit = 4'd0, ten = 4'd0, hun = 4'd0, tho = 4'd0, point = 4'd0;
    logic       blank_zero = 1'b0, seg_en = 1'b1;
    logic [3:0] sel;
    logic [7:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int         k = 0;
    logic [3:0] m_dig [0:3];
    logic [3:0] m_pt;
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    logic [7:0] lut [0:9];

    seg7_scan_4digit #(.CNT_MAX(CM), .DEAD_CYC(DC)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .unit(unit), .ten(ten), .hun(hun), .tho(tho), .point(point),
        .blank_zero(blank_zero), .seg_en(seg_en),
        .sel(sel), .seg(seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_clear();
        k = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_pt = 4'd0;
    endtask

    // Advance one clock: compute what the display must show after this edge, then sample point
    task automatic tick();
        int phase, pos, d;
        logic blk;
        logic [7:0] s;
        @(posedge sys_clk);
        k++;
        phase = k - 1;
        pos   = phase % SLOT;
        d     = (phase / SLOT) % 4;
        if (!seg_en || pos < DC) begin
            exp_sel = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_sel = 4'hF;
            exp_sel[d] = 1'b0;
            blk = blank_zero && (
                  (d == 3 && m_dig[3] == 4'd0) ||
                  (d == 2 && m_dig[3] == 4'd0 && m_dig[2] == 4'd0) ||
                  (d == 1 && m_dig[3] == 4'd0 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0));
            if (blk) s = 8'hFF;
            else if (m_dig[d] < 4'd10) s = lut[m_dig[d]];
            else s = 8'hBF;
            if (m_pt[d]) s[7] = 1'b0;
            exp_seg = s;
        end
        if (k == 1 || (phase % FRAME) == FRAME - 1) begin
            m_dig[0] = unit; m_dig[1] = ten; m_dig[2] = hun; m_dig[3] = tho;
            m_pt = point;
        end
        #1;
    endtask

    task automatic set_digits(input logic [3:0] t, input logic [3:0] h,
                              input logic [3:0] te, input logic [3:0] u);
        tho = t; hun = h; ten = te; unit = u;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        point = 4'd0; blank_zero = 1'b0; seg_en = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        n_checks++;
        if (sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel got %h expected F", sel); end
        n_checks++;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got %h expected FF", seg); end
        sys_rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_scan_basic();
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL scan_basic k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
            if (k == 3) begin
                n_checks++;
                if (sel !== 4'b1110 || seg !== 8'h99) begin
                    n_fail++;
                    $display("FAIL first_digit got sel=%h seg=%h expected sel=E seg=99", sel, seg);
                end
            end
        end
    endtask

    task automatic test_blanking();
        set_digits(4'd0, 4'd0, 4'd5, 4'd0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 0) blank_zero = 1'b1;
            if (c == 2 * FRAME) blank_zero = 1'b0;
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL blanking k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_point();
        blank_zero = 1'b1;
        point = 4'b0010;
        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        for (int c = 0; c < 4 * FRAME; c++) begin
            if (c == 2 * FRAME) begin
                point = 4'd0;
                set_digits(4'd0, 4'd0, 4'd0, 4'd0);
            end
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL point k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
        end
        blank_zero = 1'b0;
    endtask

    task automatic test_snapshot();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        for (int c = 0; c < 3 * FRAME; c++) begin
            // mid-slot of idx 1 in the second frame of this test
            if (((k / SLOT) % 4) == 1 && (k % SLOT) == 5 && c > FRAME && unit == 4'd4) unit = 4'd9;
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL snapshot k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_enable();
        set_digits(4'hC, 4'd2, 4'd3, 4'd4);
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == FRAME + 13) seg_en = 1'b0;
            if (c == FRAME + 28) seg_en = 1'b1;
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL enable k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
        end
        seg_en = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 12 * FRAME; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                unit  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                ten   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                hun   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                tho   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                point = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0) blank_zero = ~blank_zero;
            if ($urandom_range(0, 29) == 0) seg_en = ~seg_en;
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL random k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
        end
        seg_en = 1'b1;
        blank_zero = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            tick();
            if (sel === 4'b1011 && (k % SLOT) == 6) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL reset_mid_search got no hun slot expected sel=1011"); end
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (sel !== 4'hF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_async got sel=%h seg=%h expected sel=F seg=FF", sel, seg);
        end
        set_digits(4'd8, 4'd7, 4'd6, 4'd5);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_clear();
        for (int c = 0; c < FRAME + 5; c++) begin
            tick();
            n_checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL reset_restart k=%0d got sel=%h seg=%h expected sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg);
            end
            if (k == 3) begin
                n_checks++;
                if (sel !== 4'b1110 || seg !== 8'h92) begin
                    n_fail++;
                    $display("FAIL restart_idx0 got sel=%h seg=%h expected sel=E seg=92", sel, seg);
                end
            end
        end
    endtask

    initial begin
        lut[0] = 8'hC0; lut[1] = 8'hF9; lut[2] = 8'hA4; lut[3] = 8'hB0; lut[4] = 8'h99;
        lut[5] = 8'h92; lut[6] = 8'h82; lut[7] = 8'hF8; lut[8] = 8'h80; lut[9] = 8'h90;
        model_clear();
        test_reset();
        test_scan_basic();
        test_blanking();
        test_point();
        test_snapshot();
        test_enable();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
